// File: rtl/ahb_gpio_bank.sv
// ---------------------------------------------------------------------------
// ahb_gpio_bank
//
// AHB-lite zero-wait-state slave owning one GPIO bank of WIDTH pins.
// Holds the pad output values, output enables (active low), a 2-flop input
// synchroniser, and per-pin edge-triggered interrupt status with enables and
// selectable polarity. One instance per bank; irq feeds a user_irq bit.
//
// Register map (word offsets, data in bits [WIDTH-1:0], zero-extended):
//   0x00 OUT  RW   pad output values
//   0x04 OEB  RW   pad output enables, 1 = pin is an input
//   0x08 IN   RO   synchronised pad values
//   0x0C IE   RW   interrupt enable per pin
//   0x10 IS   W1C  interrupt status per pin
//   0x14 POL  RW   1 = rising edge, 0 = falling edge
//   0x18/0x1C      unmapped, read 0, writes ignored
//
// Ports:
//   HCLK, HRESETn          bus clock, async active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HREADY  address-phase controls (HSIZE ignored)
//   HWDATA                 write data, data phase
//   HRDATA                 read data, data phase
//   HREADYOUT              always 1
//   gpio_in                raw asynchronous pad inputs
//   gpio_out, gpio_oeb     pad output values / enables (active low)
//   irq                    registered level interrupt, |(IS & IE)
// ---------------------------------------------------------------------------
module ahb_gpio_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] OEB_RESET = '1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oeb,
    output logic             irq
);

    localparam logic [2:0] A_OUT = 3'd0;
    localparam logic [2:0] A_OEB = 3'd1;
    localparam logic [2:0] A_IN  = 3'd2;
    localparam logic [2:0] A_IE  = 3'd3;
    localparam logic [2:0] A_IS  = 3'd4;
    localparam logic [2:0] A_POL = 3'd5;

    // Captured address phase
    logic             valid_q, valid_d;
    logic             wr_q, wr_d;
    logic [2:0]       addr_q, addr_d;

    // Registers
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oeb_q, oeb_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] is_q, is_d;
    logic [WIDTH-1:0] pol_q, pol_d;

    // Input synchroniser and edge history
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic             irq_q, irq_d;

    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_word;

    // Bits of the bus that carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HSIZE, HTRANS[0], HWDATA};

    assign accept = HSEL & HREADY & HTRANS[1];
    assign wr_en  = valid_q & wr_q;
    assign wdata  = HWDATA[WIDTH-1:0];

    always_comb begin
        valid_d = accept;
        addr_d  = accept ? HADDR[4:2] : addr_q;
        wr_d    = accept ? HWRITE     : wr_q;
    end

    always_comb begin
        out_d = out_q;
        oeb_d = oeb_q;
        ie_d  = ie_q;
        pol_d = pol_q;
        clr   = '0;
        if (wr_en) begin
            case (addr_q)
                A_OUT:   out_d = wdata;
                A_OEB:   oeb_d = wdata;
                A_IE:    ie_d  = wdata;
                A_IS:    clr   = wdata;
                A_POL:   pol_d = wdata;
                default: ;
            endcase
        end
    end

    // Edge events are taken from the second sync stage so IS never sees
    // a metastable value; a new event wins over a simultaneous clear so
    // an edge landing during the W1C write is not lost.
    always_comb begin
        s1_d   = gpio_in;
        s2_d   = s1_q;
        prev_d = s2_q;
        ev     = (pol_q & s2_q & ~prev_q) | (~pol_q & ~s2_q & prev_q);
        is_d   = (is_q & ~clr) | ev;
        irq_d  = |(is_q & ie_q);
    end

    always_comb begin
        rd_word = '0;
        case (addr_q)
            A_OUT:   rd_word[WIDTH-1:0] = out_q;
            A_OEB:   rd_word[WIDTH-1:0] = oeb_q;
            A_IN:    rd_word[WIDTH-1:0] = s2_q;
            A_IE:    rd_word[WIDTH-1:0] = ie_q;
            A_IS:    rd_word[WIDTH-1:0] = is_q;
            A_POL:   rd_word[WIDTH-1:0] = pol_q;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            out_q   <= '0;
            oeb_q   <= OEB_RESET;
            ie_q    <= '0;
            is_q    <= '0;
            pol_q   <= '1;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            oeb_q   <= oeb_d;
            ie_q    <= ie_d;
            is_q    <= is_d;
            pol_q   <= pol_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            irq_q   <= irq_d;
        end
    end

    assign HRDATA    = (valid_q & ~wr_q) ? rd_word : 32'h0;
    assign HREADYOUT = 1'b1;
    assign gpio_out  = out_q;
    assign gpio_oeb  = oeb_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_ahb_gpio_bank.sv
module tb_ahb_gpio_bank;

    localparam int W = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = 32'h0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'b010;
    logic [31:0]   HWDATA = 32'h0;
    logic          HREADY = 1'b1;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oeb;
    logic          irq;

    ahb_gpio_bank #(.WIDTH(W)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq       (irq)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pend_wdata = 32'h0;
    logic        rd_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: tracks which data phases are reads and compares HRDATA
    // against the scoreboard; outside read data phases HRDATA must be 0.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rd_pend <= 1'b0;
        else          rd_pend <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
    end

    always @(negedge HCLK) begin
        exp_t e;
        check("hreadyout", 32'(HREADYOUT), 32'h1);
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got read data 0x%08h expected no read", HRDATA);
            end else begin
                e = exp_q.pop_front();
                check(e.name, HRDATA, e.val);
            end
        end else begin
            check("hrdata_idle", HRDATA, 32'h0);
        end
    end

    // One bus cycle: drive an address phase plus the data of the previous one.
    task automatic bus(input bit sel, input bit act, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input string name, input logic [31:0] exp);
        HSEL   = sel;
        HTRANS = act ? 2'b10 : 2'b00;
        HWRITE = wr;
        HADDR  = addr;
        HWDATA = pend_wdata;
        pend_wdata = wdata;
        if (sel && act && !wr) exp_q.push_back('{name, exp});
        @(negedge HCLK);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, 1'b1, 1'b1, addr, data, "", 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input string name, input logic [31:0] exp);
        bus(1'b1, 1'b1, 1'b0, addr, 32'h0, name, exp);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "", 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Reset values
        check("rst_gpio_out", 32'(gpio_out), 32'h00);
        check("rst_gpio_oeb", 32'(gpio_oeb), 32'hFF);
        check("rst_irq", 32'(irq), 32'h0);
        rd(32'h00, "rst_out", 32'h00);
        rd(32'h04, "rst_oeb", 32'hFF);
        rd(32'h08, "rst_in",  32'h00);
        rd(32'h0C, "rst_ie",  32'h00);
        rd(32'h10, "rst_is",  32'h00);
        rd(32'h14, "rst_pol", 32'hFF);
        idle();

        // Back-to-back writes then read
        wr(32'h00, 32'hA5);
        check("out_not_yet", 32'(gpio_out), 32'h00);
        wr(32'h04, 32'h0F);
        check("gpio_out_a5", 32'(gpio_out), 32'hA5);
        rd(32'h00, "rd_out", 32'hA5);
        check("gpio_oeb_0f", 32'(gpio_oeb), 32'h0F);
        idle();

        // Read-after-write, same register
        wr(32'h0C, 32'h01);
        rd(32'h0C, "raw_ie", 32'h01);
        idle();

        // Rising edges on bits 0 and 7, latency through sync/IS/irq
        gpio_in = 8'h81;
        rd(32'h08, "in_cycle1", 32'h00);
        rd(32'h08, "in_cycle2", 32'h81);
        check("irq_cycle2", 32'(irq), 32'h0);
        idle();
        check("irq_cycle3", 32'(irq), 32'h0);
        idle();
        check("irq_cycle4", 32'(irq), 32'h1);
        rd(32'h10, "is_rise", 32'h81);
        idle();

        // W1C of bit0
        wr(32'h10, 32'h01);
        idle();
        check("irq_hold", 32'(irq), 32'h1);
        idle();
        check("irq_cleared", 32'(irq), 32'h0);
        rd(32'h10, "is_w1c", 32'h80);
        idle();

        // Falling polarity
        wr(32'h14, 32'h00);
        idle();
        gpio_in = 8'hFF;
        repeat (5) idle();
        wr(32'h10, 32'hFF);
        idle();
        rd(32'h10, "is_clr_all", 32'h00);
        gpio_in = 8'hFE;
        repeat (5) idle();
        check("irq_fall", 32'(irq), 32'h1);
        rd(32'h10, "is_fall", 32'h01);
        gpio_in = 8'hFF;
        repeat (5) idle();
        rd(32'h10, "is_rise_ignored", 32'h01);
        idle();

        // Edge on bit3 lands in the same cycle as its W1C
        gpio_in = 8'hF7;
        idle();
        wr(32'h10, 32'h08);
        idle();
        rd(32'h10, "is_set_wins", 32'h09);
        idle();
        wr(32'h10, 32'h09);
        rd(32'h10, "is_clr2", 32'h00);
        idle();

        // Ignored transfers, RO and unmapped registers, high address bits
        bus(1'b0, 1'b1, 1'b1, 32'h00, 32'hFF, "", 32'h0);
        bus(1'b1, 1'b0, 1'b1, 32'h00, 32'hFF, "", 32'h0);
        idle();
        wr(32'h08, 32'h00);
        wr(32'h18, 32'h5A);
        rd(32'h18, "unmapped", 32'h00);
        rd(32'h00, "out_kept", 32'hA5);
        rd(32'h08, "in_ro", 32'hF7);
        rd(32'h3000_0004, "addr_hi", 32'h0F);
        idle();

        // Reset between address and data phase of a write
        gpio_in = 8'h00;
        wr(32'h0C, 32'hFF);
        repeat (4) idle();
        wr(32'h00, 32'h3C);
        HWDATA  = 32'h3C;
        pend_wdata = 32'h0;
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        idle();
        check("post_rst_gpio_out", 32'(gpio_out), 32'h00);
        check("post_rst_gpio_oeb", 32'(gpio_oeb), 32'hFF);
        check("post_rst_irq", 32'(irq), 32'h0);
        rd(32'h00, "post_rst_out", 32'h00);
        rd(32'h04, "post_rst_oeb", 32'hFF);
        rd(32'h0C, "post_rst_ie",  32'h00);
        rd(32'h10, "post_rst_is",  32'h00);
        rd(32'h14, "post_rst_pol", 32'hFF);
        idle();
        idle();

        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
